// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the round-robin data-RAM arbiter.
// GW is the width of the grant index and of the round-robin pointer.
package dmem_arbiter_pkg;

  localparam int DA_NREQ = 4;
  localparam int GW      = 3;

  typedef enum logic [1:0] {
    DA_IDLE  = 2'd0,
    DA_ISSUE = 2'd1,
    DA_WAIT  = 2'd2,
    DA_DONE  = 2'd3
  } da_state_e;

  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side request bus plus the shared RAM port, bundled for the arbiter.
// master: the cores and the RAM. slave: the arbiter serving them.
interface dmem_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_wren;
  logic [DW-1:0]      mem_q;

  modport master (
    output req, we, addr, wdata, mem_q,
    input  done, rdata, mem_addr, mem_wdata, mem_wren
  );

  modport slave (
    input  req, we, addr, wdata, mem_q,
    output done, rdata, mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request after last_i, wrapping mod NREQ.
module dmem_arbiter_rr_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int NREQ = DA_NREQ
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [GW-1:0]   last_i,
  output logic [GW-1:0]   sel_o,
  output logic            any_o
);

  logic [7:0]    req_ext;
  logic [GW-1:0] idx;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req_i;
    sel_o               = '0;
    any_o               = 1'b0;
    idx                 = last_i;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_next(idx, NREQ);
      if (!any_o && req_ext[idx]) begin
        sel_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer sharing one registered-input single-port RAM between NREQ cores.
// Each access: IDLE (grant) -> ISSUE (RAM captures) -> WAIT (q valid) -> DONE (pulse).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NREQ = DA_NREQ,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic          busy_o,
  output logic [GW-1:0] grant_id_o
);

  da_state_e       state_q, state_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_wren_q, mem_wren_d;
  logic            wr_q, wr_d;
  logic            busy_q, busy_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;

  logic [GW-1:0]   sel;
  logic            any;
  logic [7:0]      we_ext;

  dmem_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .sel_o  (sel),
    .any_o  (any)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = '0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    wr_d        = wr_q;
    grant_d     = grant_q;
    last_d      = last_q;
    we_ext           = '0;
    we_ext[NREQ-1:0] = bus.we;

    case (state_q)
      DA_IDLE: begin
        if (any) begin
          grant_d     = sel;
          last_d      = sel;
          mem_addr_d  = bus.addr[int'(sel)*AW +: AW];
          mem_wdata_d = bus.wdata[int'(sel)*DW +: DW];
          mem_wren_d  = we_ext[sel];
          wr_d        = we_ext[sel];
          state_d     = DA_ISSUE;
        end
      end
      DA_ISSUE: state_d = DA_WAIT;
      DA_WAIT: begin
        // the registered wren is already low here, so remember the access type separately
        if (!wr_q) rdata_d = bus.mem_q;
        done_d  = NREQ'(1) << grant_q;
        state_d = DA_DONE;
      end
      DA_DONE: state_d = DA_IDLE;
      default: state_d = DA_IDLE;
    endcase

    busy_d = (state_d != DA_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DA_IDLE;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      last_q      <= GW'(NREQ - 1);
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wren  = mem_wren_q;
  assign busy_o        = busy_q;
  assign grant_id_o    = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-input RAM model behind it.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] grant_id;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;

  dmem_arbiter_if #(.NREQ(4), .AW(8), .DW(8)) bus ();

  dmem_arbiter #(.NREQ(4), .AW(8), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy_o     (busy),
    .grant_id_o (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM model: address/data/wren registered, q read from the registered address
  logic [7:0] ram [256];
  logic [7:0] ram_a = 8'h00;
  logic       pre_we = 1'b0;
  logic [7:0] pre_a = 8'h00;
  logic [7:0] pre_d = 8'h00;

  always @(posedge clk) begin
    ram_a <= bus.mem_addr;
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    else if (pre_we) ram[pre_a] <= pre_d;
  end
  assign bus.mem_q = ram[ram_a];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst) chk("done_onehot", 32'($countones(bus.done) <= 1), 32'd1);

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic set_req(input int c, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.req[c]         = 1'b1;
    bus.we[c]          = w;
    bus.addr[c*8 +: 8]  = a;
    bus.wdata[c*8 +: 8] = d;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done != 4'b0) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  int prev_cyc;
  int pulses;

  initial begin
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    tick();
    preload(8'h10, 8'hA5);
    preload(8'h05, 8'h5A);
    rst = 1'b0;
    tick();

    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_rdata", 32'(bus.rdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_wren", 32'(bus.mem_wren), 32'h0);
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);

    // single read by core 2
    set_req(2, 1'b0, 8'h10, 8'h00);
    tick();
    chk("rd_addr", 32'(bus.mem_addr), 32'h10);
    chk("rd_busy", 32'(busy), 32'h1);
    chk("rd_grant", 32'(grant_id), 32'h2);
    chk("rd_done_e0", 32'(bus.done), 32'h0);
    tick();
    chk("rd_done_e1", 32'(bus.done), 32'h0);
    tick();
    chk("rd_done", 32'(bus.done), 32'h4);
    chk("rd_rdata", 32'(bus.rdata), 32'hA5);
    bus.req[2] = 1'b0;
    tick();
    chk("rd_done_e3", 32'(bus.done), 32'h0);
    chk("rd_busy_e3", 32'(busy), 32'h0);

    // write by core 0, read back by core 1
    set_req(0, 1'b1, 8'h20, 8'h3C);
    tick();
    chk("wr_wren_e0", 32'(bus.mem_wren), 32'h1);
    chk("wr_wdata", 32'(bus.mem_wdata), 32'h3C);
    chk("wr_addr", 32'(bus.mem_addr), 32'h20);
    tick();
    chk("wr_wren_e1", 32'(bus.mem_wren), 32'h0);
    tick();
    chk("wr_done", 32'(bus.done), 32'h1);
    chk("wr_rdata_kept", 32'(bus.rdata), 32'hA5);
    bus.req[0] = 1'b0;
    tick();
    set_req(1, 1'b0, 8'h20, 8'h00);
    tick(3);
    chk("rb_done", 32'(bus.done), 32'h2);
    chk("rb_rdata", 32'(bus.rdata), 32'h3C);
    bus.req[1] = 1'b0;
    tick(2);

    // all cores requesting continuously from reset
    do_reset();
    for (int c = 0; c < 4; c++) set_req(c, 1'b0, 8'h10, 8'h00);
    prev_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      wait_done();
      chk("rr_order", 32'(bus.done), 32'(1 << (g % 4)));
      if (g > 0) chk("rr_spacing", 32'(cyc - prev_cyc), 32'd4);
      prev_cyc = cyc;
    end
    bus.req = '0;
    tick(2);
    chk("rr_idle", 32'(busy), 32'h0);

    // core 3 just served; cores 0 and 3 together
    do_reset();
    set_req(3, 1'b0, 8'h10, 8'h00);
    wait_done();
    chk("c3_first", 32'(bus.done), 32'h8);
    bus.req[3] = 1'b0;
    tick();
    set_req(0, 1'b0, 8'h10, 8'h00);
    set_req(3, 1'b0, 8'h20, 8'h00);
    wait_done();
    chk("wrap_c0", 32'(bus.done), 32'h1);
    bus.req[0] = 1'b0;
    wait_done();
    chk("wrap_c3", 32'(bus.done), 32'h8);
    chk("wrap_c3_rdata", 32'(bus.rdata), 32'h3C);
    bus.req[3] = 1'b0;
    tick(2);

    // reset during ISSUE of a write
    set_req(1, 1'b1, 8'h05, 8'hFF);
    tick();
    chk("abort_wren_pre", 32'(bus.mem_wren), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_wren_async", 32'(bus.mem_wren), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    bus.req[1] = 1'b0;
    tick(2);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done != 4'b0) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    chk("abort_ram", 32'(ram[8'h05]), 32'h5A);
    chk("abort_grant", 32'(grant_id), 32'h0);
    set_req(2, 1'b0, 8'h10, 8'h00);
    set_req(3, 1'b0, 8'h10, 8'h00);
    tick();
    chk("post_rst_grant", 32'(grant_id), 32'h2);
    wait_done();
    chk("post_rst_done2", 32'(bus.done), 32'h4);
    bus.req[2] = 1'b0;
    wait_done();
    chk("post_rst_done3", 32'(bus.done), 32'h8);
    bus.req[3] = 1'b0;
    tick(2);

    // core 1 drops req during WAIT
    set_req(1, 1'b0, 8'h20, 8'h00);
    tick(2);
    bus.req[1] = 1'b0;
    tick();
    chk("drop_done", 32'(bus.done), 32'h2);
    chk("drop_rdata", 32'(bus.rdata), 32'h3C);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done != 4'b0 || busy) pulses++;
    end
    chk("drop_no_regrant", 32'(pulses), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
